wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter sharing the two ALU write ports of the physical register file among NREQ execution units (MEM, ALU0, ALU1, BR/MulDiv). Each unit pushes its result into a small private FIFO. A round-robin scheduler drains up to two FIFO heads per cycle onto registered write ports. The registered writeback address also feeds busy-table reset and issue-queue wakeup. Buffered results whose branch mask overlaps a branch kill are squashed.

## Interface
- WIDTH_REG, 7, physical register index width
- WIDTH_BRM, 3, branch mask width
- NREQ, 4, number of requesting execution units (2..8)
- DEPTH, 2, entries per requester FIFO (power of two, ≥2)
- Derived: W_PKG = WIDTH_BRM + WIDTH_REG + 32; package = { brmask, prd, data }
- i_clk  input  1  clock; everything on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_req_valid  input  NREQ  result valid, bit k = requester k
- i_req_pkg  input  NREQ*W_PKG  requester k package at bits [(k+1)*W_PKG-1 : k*W_PKG]
- o_req_ready  output  NREQ  requester k may push this cycle
- i_kill  input  WIDTH_BRM+1  { en, mask }: squash results with (brmask & mask) != 0
- o_we  output  2  write enable, port 0 = bit 0
- o_waddr  output  2*WIDTH_REG  { waddr1, waddr0 }
- o_wdata  output  64  { wdata1, wdata0 }
- o_idle  output  1  all FIFOs empty

## Operation
- Push: requester k is accepted at the edge when i_req_valid[k] & o_req_ready[k]. The package is written to FIFO k with a per-entry live bit set.
- o_req_ready[k] = ~i_rst & (count_k < DEPTH). A full FIFO deasserts ready even if it pops in the same cycle. There is no same-cycle pass-through.
- Kill, when i_kill en=1:
  - Every buffered entry with brmask & mask != 0 has its live bit cleared at the edge.
  - An incoming package that overlaps the mask in the same cycle still completes the handshake but is stored with live=0.
- Head classification per requester:
  - live head: the head's live bit is 1 and it is not being killed this cycle.
  - dead head: any other non-empty head. It pops at the edge without using a port, at most one pop per FIFO per cycle.
- Arbitration: scan requesters from rr in ascending order modulo NREQ.
  - The first live head goes to port 0, the second live head to port 1.
  - Granted heads pop at the edge.
  - rr ← (index of last grantee + 1) mod NREQ. rr is unchanged when there is no grant.
- Output registers, loaded every cycle:
  - o_we[p] = port p granted.
  - o_waddr/o_wdata take the grantee's prd/data, or 0 when the port is not granted.
- Port 1 is never granted without port 0 being granted.
- o_idle = all count_k == 0. It is combinational from registered state.
- Counters: count_k is (log2(DEPTH)+1) bits; read/write pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Reset (i_rst high at an edge) sets: all FIFOs empty, live bits 0, rr=0, o_we=0, o_waddr=0, o_wdata=0. During reset: o_req_ready=0 and o_idle=1.
- Reset mid-operation discards all buffered results with no write.
- Latency from an accepted push to o_we is 2 cycles (e.g. push in cycle 0, arbitrated in cycle 1, o_we visible in cycle 2), assuming no contention.
- Throughput is 2 writes per cycle. Each FIFO sustains 1 push and 1 pop per cycle when it is not full at the start of the cycle.
- Starvation bound: a live head is granted within ceil(NREQ/2) cycles.
- Kill is applied at the same edge as push/pop arbitration. An entry already loaded into o_waddr/o_wdata is not retracted.

## Test plan
- Single push, NREQ=4: requester 2 pushes prd=0x15, data=0xDEADBEEF in cycle 0 -> cycle 2: o_we=2'b01, waddr0=0x15, wdata0=0xDEADBEEF; cycle 3: o_we=0, o_idle=1.
- Four simultaneous pushes (prd 1,2,3,4) with rr=0 -> cycle 2: ports get prd 1 and 2; cycle 3: prd 3 and 4; rr then equals 0.
- Fill FIFO 0 (DEPTH=2) while its head cannot pop -> o_req_ready[0]=0 on the next cycle. It returns to 1 the cycle after a pop. No data is lost or duplicated (scoreboard compare).
- Kill: buffer brmask 3'b010 and 3'b001 in FIFO 1, then assert i_kill={1,3'b010} -> only the 3'b001 result is written; the squashed one pops without o_we.
- Kill race: a push with brmask 3'b100 in the same cycle as i_kill={1,3'b100} -> the handshake completes and no write ever appears.
- Reset mid-stream: assert i_rst with 3 FIFOs non-empty -> next cycle o_we=0, o_idle=1, rr=0. No buffered result is ever written after reset.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NREQ execution units push results into private FIFOs;
// a round-robin scheduler drains up to two live heads per cycle onto two
// registered register-file write ports. Results whose branch mask overlaps
// a branch kill are squashed and drained without using a port.
module wb_arbiter #(
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 3,
  parameter int NREQ      = 4,
  parameter int DEPTH     = 2
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic [NREQ-1:0]                           i_req_valid,
  input  logic [NREQ*(WIDTH_BRM+WIDTH_REG+32)-1:0]  i_req_pkg,
  output logic [NREQ-1:0]                           o_req_ready,
  input  logic [WIDTH_BRM:0]                        i_kill,
  output logic [1:0]                                o_we,
  output logic [2*WIDTH_REG-1:0]                    o_waddr,
  output logic [63:0]                               o_wdata,
  output logic                                      o_idle
);

  localparam int W_PKG = WIDTH_BRM + WIDTH_REG + 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int RW    = $clog2(NREQ);

  // Package field positions: { brmask, prd, data }
  localparam int PRD_LSB = 32;
  localparam int BRM_MSB = W_PKG - 1;

  // Per-requester FIFO state
  logic [W_PKG-1:0] mem    [NREQ][DEPTH];
  logic [DEPTH-1:0] live   [NREQ];
  logic [AW-1:0]    rd_ptr [NREQ];
  logic [AW-1:0]    wr_ptr [NREQ];
  logic [CW-1:0]    count  [NREQ];
  logic [RW-1:0]    rr;

  logic                 kill_en;
  logic [WIDTH_BRM-1:0] kill_mask;

  logic [W_PKG-1:0] head_pkg [NREQ];
  logic [W_PKG-1:0] in_pkg   [NREQ];
  logic [NREQ-1:0]  in_live;
  logic [NREQ-1:0]  head_live;
  logic [NREQ-1:0]  head_dead;
  logic [NREQ-1:0]  push;
  logic [NREQ-1:0]  pop;

  logic [RW-1:0] scan_idx [NREQ];
  logic          gnt0_vld, gnt1_vld;
  logic [RW-1:0] gnt0_idx, gnt1_idx;
  logic [RW-1:0] rr_next;

  assign kill_en   = i_kill[WIDTH_BRM];
  assign kill_mask = i_kill[WIDTH_BRM-1:0];

  // Handshake, incoming-kill check and head classification per requester
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    o_req_ready = '0;
    push        = '0;
    in_live     = '0;
    head_live   = '0;
    head_dead   = '0;
    for (int k = 0; k < NREQ; k++) begin
      in_pkg[k]      = i_req_pkg[k*W_PKG +: W_PKG];
      head_pkg[k]    = mem[k][rd_ptr[k]];
      o_req_ready[k] = !i_rst && (count[k] < CW'(DEPTH));
      push[k]        = i_req_valid[k] && o_req_ready[k];
      in_live[k]     = !(kill_en && |(in_pkg[k][BRM_MSB -: WIDTH_BRM] & kill_mask));
      head_live[k]   = (count[k] != '0) && live[k][rd_ptr[k]] &&
                       !(kill_en && |(head_pkg[k][BRM_MSB -: WIDTH_BRM] & kill_mask));
      head_dead[k]   = (count[k] != '0) && !head_live[k];
    end
  end

  // Round-robin scan order starting at rr
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      scan_idx[i] = RW'((int'(rr) + i) % NREQ);
    end
  end

  // Pick the first two live heads in scan order; dead heads pop for free
  always_comb begin
    gnt0_vld = 1'b0;
    gnt1_vld = 1'b0;
    gnt0_idx = '0;
    gnt1_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (head_live[scan_idx[i]]) begin
        if (!gnt0_vld) begin
          gnt0_vld = 1'b1;
          gnt0_idx = scan_idx[i];
        end else if (!gnt1_vld) begin
          gnt1_vld = 1'b1;
          gnt1_idx = scan_idx[i];
        end
      end
    end

    pop = head_dead;
    if (gnt0_vld) pop[gnt0_idx] = 1'b1;
    if (gnt1_vld) pop[gnt1_idx] = 1'b1;

    rr_next = rr;
    if (gnt1_vld)      rr_next = RW'((int'(gnt1_idx) + 1) % NREQ);
    else if (gnt0_vld) rr_next = RW'((int'(gnt0_idx) + 1) % NREQ);
  end

  // FIFO payload storage
  always_ff @(posedge i_clk) begin
    // NOTE: the payload array has no reset; validity is carried entirely by
    // count and the live bits, so clearing the data would only cost logic.
    for (int k = 0; k < NREQ; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= in_pkg[k];
    end
  end

  // FIFO control, live bits, round-robin pointer and registered write ports
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      for (int k = 0; k < NREQ; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
        live[k]   <= '0;
      end
      rr      <= '0;
      o_we    <= '0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (kill_en && |(mem[k][j][BRM_MSB -: WIDTH_BRM] & kill_mask)) begin
            live[k][j] <= 1'b0;
          end
        end
        // The push slot is empty, so its fresh live bit overrides any kill above
        if (push[k]) begin
          live[k][wr_ptr[k]] <= in_live[k];
          wr_ptr[k]          <= wr_ptr[k] + AW'(1);
        end
        if (pop[k]) rd_ptr[k] <= rd_ptr[k] + AW'(1);
        count[k] <= count[k] + CW'(push[k]) - CW'(pop[k]);
      end

      rr      <= rr_next;
      o_we    <= {gnt1_vld, gnt0_vld};
      o_waddr <= {gnt1_vld ? head_pkg[gnt1_idx][PRD_LSB +: WIDTH_REG] : {WIDTH_REG{1'b0}},
                  gnt0_vld ? head_pkg[gnt0_idx][PRD_LSB +: WIDTH_REG] : {WIDTH_REG{1'b0}}};
      o_wdata <= {gnt1_vld ? head_pkg[gnt1_idx][31:0] : 32'h0,
                  gnt0_vld ? head_pkg[gnt0_idx][31:0] : 32'h0};
    end
  end

  // Idle when every FIFO is empty
  always_comb begin
    o_idle = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      if (count[k] != '0) o_idle = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: expected writes are queued as stimulus
// is driven and popped in order as the write ports fire.
module tb_wb_arbiter;

  localparam int WR = 7;
  localparam int WB = 3;
  localparam int NR = 4;
  localparam int DP = 2;
  localparam int WP = WB + WR + 32;

  typedef struct packed {
    logic [WR-1:0] prd;
    logic [31:0]   data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*WP-1:0] req_pkg;
  logic [NR-1:0]    req_ready;
  logic [WB:0]      kill;
  logic [1:0]       we;
  logic [2*WR-1:0]  waddr;
  logic [63:0]      wdata;
  logic             idle;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.WIDTH_REG(WR), .WIDTH_BRM(WB), .NREQ(NR), .DEPTH(DP)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_pkg   (req_pkg),
    .o_req_ready (req_ready),
    .i_kill      (kill),
    .o_we        (we),
    .o_waddr     (waddr),
    .o_wdata     (wdata),
    .o_idle      (idle)
  );

  task automatic clear_inputs();
    req_valid = '0;
    req_pkg   = '0;
    kill      = '0;
  endtask

  task automatic push_req(input int k, input logic [WB-1:0] brm,
                          input logic [WR-1:0] prd, input logic [31:0] data);
    req_valid[k]         = 1'b1;
    req_pkg[k*WP +: WP]  = {brm, prd, data};
  endtask

  task automatic expect_wr(input logic [WR-1:0] prd, input logic [31:0] data);
    wr_t e;
    e.prd  = prd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then compare every fired write port with the scoreboard
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (we[p]) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write port%0d: got prd=%h data=%h, required no write",
                   p, waddr[p*WR +: WR], wdata[p*32 +: 32]);
        end else begin
          e = exp_q.pop_front();
          if ({waddr[p*WR +: WR], wdata[p*32 +: 32]} !== {e.prd, e.data}) begin
            errors++;
            $display("FAIL write_data port%0d: got prd=%h data=%h, required prd=%h data=%h",
                     p, waddr[p*WR +: WR], wdata[p*32 +: 32], e.prd, e.data);
          end
        end
      end else if (waddr[p*WR +: WR] !== '0 || wdata[p*32 +: 32] !== 32'h0) begin
        errors++;
        $display("FAIL idle_port_zero port%0d: got prd=%h data=%h, required 0",
                 p, waddr[p*WR +: WR], wdata[p*32 +: 32]);
      end
    end
    checks++;
    if (we === 2'b10) begin
      errors++;
      $display("FAIL port1_alone: got we=%b, required port0 granted whenever port1 is", we);
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Run until quiet within a cycle budget, then confirm every expected write appeared
  task automatic drain(input int max_cycles, input string name);
    int n = 0;
    while (!(idle === 1'b1 && we === 2'b00) && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (!(idle === 1'b1 && we === 2'b00)) begin
      errors++;
      $display("FAIL %s_drain_timeout: got idle=%b we=%b after %0d cycles, required idle=1 we=00",
               name, idle, we, max_cycles);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst       = 1'b1;
    req_valid = '1;
    step();
    checks++;
    if (we !== 2'b00 || waddr !== '0 || wdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b waddr=%h wdata=%h, required all 0", we, waddr, wdata);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 0000", req_ready);
    end
    step();
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got %b, required 1", idle);
    end
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b1111) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1111", req_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    push_req(2, 3'b000, 7'h15, 32'hDEADBEEF);
    expect_wr(7'h15, 32'hDEADBEEF);
    step();
    clear_inputs();
    checks++;
    if (we !== 2'b00 || idle !== 1'b0) begin
      errors++;
      $display("FAIL single_cycle1: got we=%b idle=%b, required we=00 idle=0", we, idle);
    end
    step();
    checks++;
    if (we !== 2'b01 || waddr[WR-1:0] !== 7'h15 || wdata[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_cycle2: got we=%b waddr0=%h wdata0=%h, required we=01 15 deadbeef",
               we, waddr[WR-1:0], wdata[31:0]);
    end
    step();
    checks++;
    if (we !== 2'b00 || idle !== 1'b1) begin
      errors++;
      $display("FAIL single_cycle3: got we=%b idle=%b, required we=00 idle=1", we, idle);
    end
    drain(4, "single");
  endtask

  task automatic test_four();
    do_reset();
    for (int k = 0; k < NR; k++) begin
      push_req(k, 3'b000, 7'(k + 1), 32'hA000_0000 + 32'(k));
      expect_wr(7'(k + 1), 32'hA000_0000 + 32'(k));
    end
    step();
    clear_inputs();
    step();
    checks++;
    if (we !== 2'b11 || waddr !== {7'd2, 7'd1}) begin
      errors++;
      $display("FAIL four_cycle2: got we=%b waddr=%h, required we=11 prd 2,1", we, waddr);
    end
    step();
    checks++;
    if (we !== 2'b11 || waddr !== {7'd4, 7'd3}) begin
      errors++;
      $display("FAIL four_cycle3: got we=%b waddr=%h, required we=11 prd 4,3", we, waddr);
    end
    // rr must be back at 0: requester 0 beats requester 3
    push_req(3, 3'b000, 7'h0E, 32'h0000_000E);
    push_req(0, 3'b000, 7'h0D, 32'h0000_000D);
    expect_wr(7'h0D, 32'h0000_000D);
    expect_wr(7'h0E, 32'h0000_000E);
    step();
    clear_inputs();
    step();
    checks++;
    if (we !== 2'b11 || waddr !== {7'h0E, 7'h0D}) begin
      errors++;
      $display("FAIL four_rr_wrap: got we=%b waddr=%h, required we=11 prd 0e,0d", we, waddr);
    end
    drain(6, "four");
  endtask

  task automatic test_full();
    do_reset();
    push_req(0, 3'b000, 7'h20, 32'h2020_2020);
    expect_wr(7'h20, 32'h2020_2020);
    step();
    clear_inputs();
    step();                                  // rr now 1
    push_req(0, 3'b000, 7'h21, 32'h2121_2121);
    push_req(1, 3'b000, 7'h31, 32'h3131_3131);
    push_req(2, 3'b000, 7'h41, 32'h4141_4141);
    expect_wr(7'h31, 32'h3131_3131);
    expect_wr(7'h41, 32'h4141_4141);
    expect_wr(7'h21, 32'h2121_2121);
    expect_wr(7'h22, 32'h2222_2222);
    expect_wr(7'h23, 32'h2323_2323);
    step();
    clear_inputs();
    push_req(0, 3'b000, 7'h22, 32'h2222_2222);
    step();
    push_req(0, 3'b000, 7'h23, 32'h2323_2323);
    checks++;
    if (req_ready !== 4'b1110) begin
      errors++;
      $display("FAIL full_ready_low: got %b, required 1110", req_ready);
    end
    checks++;
    if (we !== 2'b11) begin
      errors++;
      $display("FAIL full_contention: got we=%b, required 11", we);
    end
    step();
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_back: got %b, required 1", req_ready[0]);
    end
    step();
    clear_inputs();
    drain(10, "full");
  endtask

  task automatic test_kill();
    do_reset();
    push_req(1, 3'b000, 7'h50, 32'h5050_5050);
    expect_wr(7'h50, 32'h5050_5050);
    step();
    clear_inputs();
    step();                                  // rr now 2
    push_req(2, 3'b000, 7'h60, 32'h6060_6060);
    push_req(3, 3'b000, 7'h70, 32'h7070_7070);
    push_req(1, 3'b010, 7'h51, 32'h5151_5151);
    expect_wr(7'h60, 32'h6060_6060);
    expect_wr(7'h70, 32'h7070_7070);
    expect_wr(7'h52, 32'h5252_5252);
    step();
    clear_inputs();
    push_req(1, 3'b001, 7'h52, 32'h5252_5252);
    step();
    clear_inputs();
    kill = {1'b1, 3'b010};
    checks++;
    if (we !== 2'b11) begin
      errors++;
      $display("FAIL kill_others: got we=%b, required 11", we);
    end
    step();
    kill = '0;
    checks++;
    if (we !== 2'b00 || idle !== 1'b0) begin
      errors++;
      $display("FAIL kill_squash: got we=%b idle=%b, required we=00 idle=0", we, idle);
    end
    step();
    checks++;
    if (we !== 2'b01 || waddr[WR-1:0] !== 7'h52) begin
      errors++;
      $display("FAIL kill_survivor: got we=%b waddr0=%h, required we=01 prd 52", we, waddr[WR-1:0]);
    end
    drain(6, "kill");
  endtask

  task automatic test_kill_race();
    do_reset();
    push_req(3, 3'b100, 7'h7F, 32'h1234_5678);
    kill = {1'b1, 3'b100};
    #1;
    checks++;
    if (req_ready[3] !== 1'b1) begin
      errors++;
      $display("FAIL race_handshake: got ready=%b, required 1", req_ready[3]);
    end
    step();
    clear_inputs();
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL race_stored: got idle=%b, required 0", idle);
    end
    step();
    checks++;
    if (idle !== 1'b1 || we !== 2'b00) begin
      errors++;
      $display("FAIL race_dropped: got idle=%b we=%b, required idle=1 we=00", idle, we);
    end
    step();
    drain(5, "race");
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_req(0, 3'b000, 7'h01, 32'hC000_0001);
    push_req(1, 3'b000, 7'h02, 32'hC000_0002);
    push_req(2, 3'b000, 7'h03, 32'hC000_0003);
    expect_wr(7'h01, 32'hC000_0001);
    expect_wr(7'h02, 32'hC000_0002);
    step();
    clear_inputs();
    push_req(0, 3'b000, 7'h11, 32'hC000_0011);
    push_req(1, 3'b000, 7'h12, 32'hC000_0012);
    push_req(2, 3'b000, 7'h13, 32'hC000_0013);
    step();
    clear_inputs();
    rst = 1'b1;
    step();
    checks++;
    if (we !== 2'b00 || idle !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_state: got we=%b idle=%b ready=%b, required 00 1 0000",
               we, idle, req_ready);
    end
    rst = 1'b0;
    // rr must have returned to 0: requester 0 beats requester 3
    push_req(3, 3'b000, 7'h2B, 32'hC000_002B);
    push_req(0, 3'b000, 7'h2A, 32'hC000_002A);
    expect_wr(7'h2A, 32'hC000_002A);
    expect_wr(7'h2B, 32'hC000_002B);
    step();
    clear_inputs();
    step();
    checks++;
    if (we !== 2'b11 || waddr !== {7'h2B, 7'h2A}) begin
      errors++;
      $display("FAIL midreset_rr: got we=%b waddr=%h, required we=11 prd 2b,2a", we, waddr);
    end
    drain(10, "midreset");
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_four();
    test_full();
    test_kill();
    test_kill_race();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule
